alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 32 +++
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_rr_grant.sv | 22 ++
 rtl/alu_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states, operand
// width, ALU opcode constants and the latched-operation record.
package alu_arbiter_pkg;

    localparam int DATA_W = 64;
    localparam int OPR_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic [OPR_W-1:0] OP_PASS_A  = 5'b00000;
    localparam logic [OPR_W-1:0] OP_PASS_B  = 5'b00001;
    localparam logic [OPR_W-1:0] OP_ADD     = 5'b00010;
    localparam logic [OPR_W-1:0] OP_SUB     = 5'b00011;
    localparam logic [OPR_W-1:0] OP_CMUL    = 5'b00100;
    localparam logic [OPR_W-1:0] OP_MUL     = 5'b00110;
    localparam logic [OPR_W-1:0] OP_CMP     = 5'b01000;
    localparam logic [OPR_W-1:0] OP_POLAR_A = 5'b01001;
    localparam logic [OPR_W-1:0] OP_POLAR_B = 5'b01010;

    // One accepted operation as it is held for the shared ALU.
    typedef struct packed {
        logic [OPR_W-1:0]  opr;
        logic [DATA_W-1:0] in_a;
        logic [DATA_W-1:0] in_b;
    } alu_op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester-side and ALU-side signals around the arbiter.
// Modport 'slave' is the arbiter's view; 'master' is the environment's view
// (requesters plus the shared ALU).
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [OPR_W-1:0]  req0_opr;
    logic [DATA_W-1:0] req0_inA;
    logic [DATA_W-1:0] req0_inB;
    logic [DATA_W-1:0] req0_result;
    logic              req0_rvalid;
    logic              req0_err;

    logic              req1_valid;
    logic              req1_ready;
    logic [OPR_W-1:0]  req1_opr;
    logic [DATA_W-1:0] req1_inA;
    logic [DATA_W-1:0] req1_inB;
    logic [DATA_W-1:0] req1_result;
    logic              req1_rvalid;
    logic              req1_err;

    logic              alu_start;
    logic [OPR_W-1:0]  alu_opr;
    logic [DATA_W-1:0] alu_inA;
    logic [DATA_W-1:0] alu_inB;
    logic [DATA_W-1:0] alu_outAB;
    logic              alu_done;

    modport slave (
        input  req0_valid, req0_opr, req0_inA, req0_inB,
        output req0_ready, req0_result, req0_rvalid, req0_err,
        input  req1_valid, req1_opr, req1_inA, req1_inB,
        output req1_ready, req1_result, req1_rvalid, req1_err,
        output alu_start, alu_opr, alu_inA, alu_inB,
        input  alu_outAB, alu_done
    );

    modport master (
        output req0_valid, req0_opr, req0_inA, req0_inB,
        input  req0_ready, req0_result, req0_rvalid, req0_err,
        output req1_valid, req1_opr, req1_inA, req1_inB,
        input  req1_ready, req1_result, req1_rvalid, req1_err,
        input  alu_start, alu_opr, alu_inA, alu_inB,
        output alu_outAB, alu_done
    );

endinterface

// File: rtl/alu_rr_grant.sv
// Two-way round-robin grant: a lone valid requester wins; on contention the
// requester that was not granted last wins.
module alu_rr_grant (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_idx
);

    // Pick the winner from the current valids and the last-grant pointer.
    always_comb begin
        gnt_valid = valid0 | valid1;
        gnt_idx   = 1'b0;
        if (valid0 && valid1) begin
            gnt_idx = ~last_grant;
        end else if (valid1) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbiter sharing one multi-cycle ALU between two requesters.
// IDLE grants one requester, ISSUE pulses alu_start, WAIT holds operands until
// alu_done, RESP returns the captured result to the granted requester.
// Optional watchdog: define ALU_ARB_TIMEOUT_EN to abort a WAIT after
// TIMEOUT_CYCLES cycles with err=1 and result=0.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clock,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e        state_q, state_d;
    alu_op_t           op_q, op_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] res0_q, res0_d;
    logic [DATA_W-1:0] res1_q, res1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;

    logic              gnt_valid;
    logic              gnt_idx;
    logic              ready0;
    logic              ready1;
    logic              alu_start;
    alu_op_t           req0_op;
    alu_op_t           req1_op;

    assign req0_op = {bus.req0_opr, bus.req0_inA, bus.req0_inB};
    assign req1_op = {bus.req1_opr, bus.req1_inA, bus.req1_inB};

    alu_rr_grant u_grant (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out_q, timed_out_d;
    logic             err0_q, err0_d;
    logic             err1_q, err1_d;
`endif

    // Next-state, grant and response logic for the four-state FSM.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latches).
        state_d   = state_q;
        op_d      = op_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cap_d     = cap_q;
        res0_d    = res0_q;
        res1_d    = res1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;
        alu_start = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                ready0 = gnt_valid && !gnt_idx;
                ready1 = gnt_valid && gnt_idx;
                if (gnt_valid) begin
                    state_d = ST_ISSUE;
                    gnt_d   = gnt_idx;
                    last_d  = gnt_idx;
                    op_d    = gnt_idx ? req1_op : req0_op;
                end
            end
            ST_ISSUE: begin
                alu_start = 1'b1;
                state_d   = ST_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
                cnt_d       = '0;
                timed_out_d = 1'b0;
`endif
            end
            ST_WAIT: begin
                if (bus.alu_done) begin
                    cap_d   = bus.alu_outAB;
                    state_d = ST_RESP;
                end
`ifdef ALU_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    cap_d       = '0;
                    timed_out_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (!gnt_q) begin
                    res0_d    = cap_q;
                    rvalid0_d = 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
                    err0_d    = timed_out_q;
`endif
                end else begin
                    res1_d    = cap_q;
                    rvalid1_d = 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
                    err1_d    = timed_out_q;
`endif
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: all registers, including result and operand holding registers, are reset so every output is 0 in reset.
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            cap_q     <= '0;
            res0_q    <= '0;
            res1_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q   <= state_d;
            op_q      <= op_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cap_q     <= cap_d;
            res0_q    <= res0_d;
            res1_q    <= res1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    // Watchdog counter and error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
        end
    end

    assign bus.req0_err = err0_q;
    assign bus.req1_err = err1_q;
`else
    assign bus.req0_err = 1'b0;
    assign bus.req1_err = 1'b0;
`endif

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.req0_result = res0_q;
    assign bus.req1_result = res1_q;
    assign bus.req0_rvalid = rvalid0_q;
    assign bus.req1_rvalid = rvalid1_q;
    assign bus.alu_start   = alu_start;
    assign bus.alu_opr     = op_q.opr;
    assign bus.alu_inA     = op_q.in_a;
    assign bus.alu_inB     = op_q.in_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU with programmable
// latency, per-requester scoreboards checked on every rvalid (result, err,
// latency, other requester untouched), plus directed reset/contention cases.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int TMO = 64;
    localparam logic [63:0] GARBAGE = 64'hbad0_bad0_bad0_bad0;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [63:0] exp_last [2];
    int          rv0_cnt = 0;
    int          rv1_cnt = 0;
    int          start_cnt = 0;
    int          outstanding = 0;
    int          last_rv1 = -1;
    bit          b2b_mode = 1'b0;

    // ALU model controls
    int          alu_lat = 1;
    bit          alu_dead = 1'b0;
    bit          force_iss_en = 1'b0;
    int          rst_gen = 0;
    logic        model_done = 1'b0;
    logic        force_idle = 1'b0;
    logic        force_iss = 1'b0;
    logic [63:0] model_out = GARBAGE;

    assign bus.alu_done  = model_done | force_idle | force_iss;
    assign bus.alu_outAB = model_out;

    logic [4:0]  stg_opr [2];
    logic [63:0] stg_a   [2];
    logic [63:0] stg_b   [2];
    logic [63:0] stg_res [2];
    logic        stg_err [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] alu_ref(input logic [4:0] opr, input logic [63:0] a, input logic [63:0] b);
        logic signed [31:0] ar, ai, br, bi;
        logic [31:0] rr, ri;
        ar = a[63:32]; ai = a[31:0]; br = b[63:32]; bi = b[31:0];
        case (opr)
            OP_PASS_A: return a;
            OP_PASS_B: return b;
            OP_ADD:  begin rr = ar + br; ri = ai + bi; end
            OP_SUB:  begin rr = ar - br; ri = ai - bi; end
            OP_CMUL: begin rr = ar * br - ai * bi; ri = ar * bi + ai * br; end
            default: begin rr = ar ^ br; ri = ai ^ bi; end
        endcase
        return {rr, ri};
    endfunction

    function automatic logic get_ready(input int n);
        return (n == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction
    function automatic logic get_rvalid(input int n);
        return (n == 0) ? bus.req0_rvalid : bus.req1_rvalid;
    endfunction
    function automatic logic [63:0] get_res(input int n);
        return (n == 0) ? bus.req0_result : bus.req1_result;
    endfunction
    function automatic logic get_err(input int n);
        return (n == 0) ? bus.req0_err : bus.req1_err;
    endfunction

    task automatic drive_req(input int n, input logic v);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_opr = stg_opr[0];
            bus.req0_inA = stg_a[0]; bus.req0_inB = stg_b[0];
        end else begin
            bus.req1_valid = v; bus.req1_opr = stg_opr[1];
            bus.req1_inA = stg_a[1]; bus.req1_inB = stg_b[1];
        end
    endtask

    task automatic stage(input int n, input logic [4:0] opr, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] res, input logic err);
        stg_opr[n] = opr; stg_a[n] = a; stg_b[n] = b; stg_res[n] = res; stg_err[n] = err;
    endtask

    // Raise the masked requests and hold each until accepted; expectations are
    // pushed at acceptance. 'first' returns the index accepted first.
    task automatic issue(input logic [1:0] mask, input bit do_push, output int first);
        logic [1:0] pend;
        logic [1:0] acc;
        exp_t e;
        pend  = mask;
        first = -1;
        @(posedge clk); #1;
        for (int n = 0; n < 2; n++) if (pend[n]) drive_req(n, 1'b1);
        for (int k = 0; k < 50 && pend != 2'b00; k++) begin
            acc = 2'b00;
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (pend[n] && get_ready(n)) begin
                    acc[n]  = 1'b1;
                    pend[n] = 1'b0;
                    if (first < 0) first = n;
                    if (do_push) begin
                        e.res = stg_res[n];
                        e.err = stg_err[n];
                        e.due = alu_dead ? cyc + TMO + 3 : cyc + alu_lat + 3;
                        if (n == 0) sb0.push_back(e); else sb1.push_back(e);
                    end
                end
            end
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) if (acc[n]) drive_req(n, 1'b0);
        end
        check("accept_pending", 64'(pend), 64'd0);
        for (int n = 0; n < 2; n++) drive_req(n, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #2;
            if (sb0.size() == 0 && sb1.size() == 0) break;
        end
        check(tag, 64'(sb0.size() + sb1.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready0"},  64'(bus.req0_ready),  64'd0);
        check({tag, "_ready1"},  64'(bus.req1_ready),  64'd0);
        check({tag, "_rvalid0"}, 64'(bus.req0_rvalid), 64'd0);
        check({tag, "_rvalid1"}, 64'(bus.req1_rvalid), 64'd0);
        check({tag, "_err0"},    64'(bus.req0_err),    64'd0);
        check({tag, "_err1"},    64'(bus.req1_err),    64'd0);
        check({tag, "_result0"}, bus.req0_result,      64'd0);
        check({tag, "_result1"}, bus.req1_result,      64'd0);
        check({tag, "_start"},   64'(bus.alu_start),   64'd0);
        check({tag, "_opr"},     64'(bus.alu_opr),     64'd0);
        check({tag, "_inA"},     bus.alu_inA,          64'd0);
        check({tag, "_inB"},     bus.alu_inB,          64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1;
        rst_gen++;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check_all_zero(tag);
        sb0.delete();
        sb1.delete();
        exp_last[0] = '0;
        exp_last[1] = '0;
        outstanding = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic on_rvalid(input int n);
        exp_t e;
        int other;
        other = 1 - n;
        if (n == 0) rv0_cnt++; else rv1_cnt++;
        outstanding = 0;
        if ((n == 0 && sb0.size() == 0) || (n == 1 && sb1.size() == 0)) begin
            check($sformatf("r%0d_spurious_rvalid", n), 64'(get_rvalid(n)), 64'd0);
            return;
        end
        if (n == 0) e = sb0.pop_front(); else e = sb1.pop_front();
        check($sformatf("r%0d_result", n), get_res(n), e.res);
        check($sformatf("r%0d_err", n), 64'(get_err(n)), 64'(e.err));
        check($sformatf("r%0d_latency_cycle", n), 64'(cyc), 64'(e.due));
        check($sformatf("r%0d_other_rvalid", n), 64'(get_rvalid(other)), 64'd0);
        check($sformatf("r%0d_other_result", n), get_res(other), exp_last[other]);
        exp_last[n] = e.res;
        if (n == 1 && b2b_mode) begin
            if (last_rv1 >= 0) check("b2b_rvalid_period", 64'(cyc - last_rv1), 64'd5);
            last_rv1 = cyc;
        end
    endtask

    // Response monitor and issue-overlap check.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.alu_start) begin
                start_cnt++;
                check("start_before_done", 64'(outstanding), 64'd0);
                outstanding = 1;
            end
            if (model_done) outstanding = 0;
            if (bus.req0_rvalid) on_rvalid(0);
            if (bus.req1_rvalid) on_rvalid(1);
        end
    end

    // Behavioural ALU: result computed from the operands still presented
    // when done fires, so operands must be held through WAIT.
    initial begin : alu_model
        int g;
        forever begin
            @(negedge clk);
            if (bus.alu_start && !rst && !alu_dead) begin
                g = rst_gen;
                if (force_iss_en) force_iss = 1'b1;
                @(posedge clk); #1;
                force_iss = 1'b0;
                for (int k = 1; k < alu_lat; k++) begin
                    @(posedge clk); #1;
                end
                if (g == rst_gen && !rst) begin
                    model_done = 1'b1;
                    model_out  = alu_ref(bus.alu_opr, bus.alu_inA, bus.alu_inB);
                    @(posedge clk); #1;
                    model_done = 1'b0;
                    model_out  = GARBAGE;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int first;
        int rv0_before, rv1_before, st_before;
        logic [63:0] a, b;
        exp_last[0] = '0;
        exp_last[1] = '0;
        for (int n = 0; n < 2; n++) stage(n, OP_PASS_A, '0, '0, '0, 1'b0);
        drive_req(0, 1'b0);
        drive_req(1, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("after_reset");

        // Single requester ADD
        stage(0, OP_ADD, 64'h0000_00ff_0000_00ff, 64'h0000_00ff_0000_00ff, 64'h0000_01fe_0000_01fe, 1'b0);
        issue(2'b01, 1'b1, first);
        wait_drain("drain_add");
        repeat (3) @(posedge clk);
        check("add_rv0_count", 64'(rv0_cnt), 64'd1);
        check("add_rv1_count", 64'(rv1_cnt), 64'd0);

        // Contention after reset: req0 first, then alternate
        do_reset("rst_pre_rr");
        stage(0, OP_SUB, 64'h0000_0005_0000_0007, 64'h0000_0002_0000_0009, 64'h0000_0003_ffff_fffe, 1'b0);
        stage(1, OP_CMUL, 64'h0000_0001_0000_0003, 64'h0000_0002_0000_0002, 64'hffff_fffc_0000_0008, 1'b0);
        issue(2'b11, 1'b1, first);
        check("rr_first_after_reset", 64'(first), 64'd0);
        wait_drain("drain_rr1");
        issue(2'b11, 1'b1, first);
        check("rr_third_contention", 64'(first), 64'd0);
        wait_drain("drain_rr2");
        stage(0, OP_PASS_B, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888, 1'b0);
        issue(2'b01, 1'b1, first);
        wait_drain("drain_solo0");
        issue(2'b11, 1'b1, first);
        check("rr_after_req0_solo", 64'(first), 64'd1);
        wait_drain("drain_rr3");

        // alu_done in IDLE and in ISSUE must be ignored
        rv0_before = rv0_cnt; rv1_before = rv1_cnt; st_before = start_cnt;
        @(posedge clk); #1;
        force_idle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        force_idle = 1'b0;
        repeat (3) @(posedge clk);
        check("idle_done_rvalid0", 64'(rv0_cnt - rv0_before), 64'd0);
        check("idle_done_rvalid1", 64'(rv1_cnt - rv1_before), 64'd0);
        check("idle_done_start", 64'(start_cnt - st_before), 64'd0);
        alu_lat = 3;
        force_iss_en = 1'b1;
        a = 64'h0123_4567_89ab_cdef;
        b = 64'hfedc_ba98_7654_3210;
        stage(1, OP_ADD, a, b, alu_ref(OP_ADD, a, b), 1'b0);
        issue(2'b10, 1'b1, first);
        wait_drain("drain_issue_done");
        force_iss_en = 1'b0;

        // Back-to-back req1 with a 1-cycle ALU
        alu_lat  = 1;
        b2b_mode = 1'b1;
        last_rv1 = -1;
        for (int k = 0; k < 4; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            stage(1, (k % 2 == 0) ? OP_SUB : OP_CMUL, a, b, alu_ref((k % 2 == 0) ? OP_SUB : OP_CMUL, a, b), 1'b0);
            issue(2'b10, 1'b1, first);
            wait_drain($sformatf("drain_b2b_%0d", k));
        end
        b2b_mode = 1'b0;

        // Reset during WAIT of POLAR_A
        alu_lat = 10;
        rv1_before = rv1_cnt;
        stage(1, OP_POLAR_A, 64'h0000_0003_0000_0004, 64'h0, 64'h0, 1'b0);
        issue(2'b10, 1'b0, first);
        repeat (3) @(posedge clk);
        do_reset("rst_in_wait");
        repeat (15) @(posedge clk);
        check("abandoned_no_rvalid1", 64'(rv1_cnt - rv1_before), 64'd0);
        alu_lat = 2;
        stage(0, OP_PASS_A, 64'h0000_0001_0000_0001, 64'h0000_0009_0000_0009, 64'h0000_0001_0000_0001, 1'b0);
        issue(2'b01, 1'b1, first);
        wait_drain("drain_after_abort");

        // ALU that never completes
        alu_dead = 1'b1;
        rv0_before = rv0_cnt;
        stage(0, OP_MUL, 64'h0000_0002_0000_0003, 64'h0000_0004_0000_0005, 64'h0, 1'b1);
`ifdef ALU_ARB_TIMEOUT_EN
        issue(2'b01, 1'b1, first);
        wait_drain("drain_timeout");
        check("timeout_rvalid_count", 64'(rv0_cnt - rv0_before), 64'd1);
`else
        issue(2'b01, 1'b0, first);
        repeat (150) @(posedge clk);
        check("no_timeout_no_rvalid", 64'(rv0_cnt - rv0_before), 64'd0);
`endif
        alu_dead = 1'b0;
        do_reset("rst_after_stall");
        alu_lat = 1;
        a = 64'h7fff_ffff_0000_0001;
        b = 64'h0000_0001_ffff_ffff;
        stage(1, OP_ADD, a, b, alu_ref(OP_ADD, a, b), 1'b0);
        issue(2'b10, 1'b1, first);
        wait_drain("drain_recovery");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
